// File: rtl/pe_typeb_scheduler.sv
// pe_typeb_scheduler
//   Round-robin front end that shares one PE_typeB-style converter/bypass PE
//   among NUM_REQ requesters. Issue is zero-cycle (ready and the PE input are
//   combinational from the request). A {valid, tag} pipe of LATENCY stages
//   follows each issue so that the PE result can be steered back to the
//   requester that issued it. The PE selects its output on the live op line, so
//   op only changes after the pipe has drained (RUN -> DRAIN -> SWITCH -> RUN).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester handshake, ready is one-hot
//   req_data            operands, requester i at [i*DWIDTH +: DWIDTH]
//   req_op              2 bits per requester, bit 0 = convert(1)/bypass(0)
//   pe_inp1, pe_t_valid_inp1, pe_op   shared PE input side
//   pe_out1, pe_t_valid_out1          shared PE output side
//   rsp_valid/rsp_data  registered one-hot response, shared data bus
//   busy                results in flight or an op switch in progress
//   err_orphan          sticky: PE valid and tag pipe tail disagreed
module pe_typeb_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int DWIDTH  = 64,
  parameter int TAGW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]         pe_inp1,
  output logic                      pe_t_valid_inp1,
  output logic [1:0]                pe_op,
  input  logic [DWIDTH-1:0]         pe_out1,
  input  logic                      pe_t_valid_out1,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                      busy,
  output logic                      err_orphan
);

  localparam int IFW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_cur_op;
  logic                r_pend_op;
  logic                r_lock_valid;
  logic [TAGW-1:0]     r_lock_id;
  logic [TAGW-1:0]     r_rr_ptr;
  logic [IFW-1:0]      r_inflight;
  logic                r_tag_v  [LATENCY];
  logic [TAGW-1:0]     r_tag_id [LATENCY];
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DWIDTH-1:0]   r_rsp_data;
  logic                r_err_orphan;

  logic                w_rr_found;
  logic [TAGW-1:0]     w_rr_id;
  logic                w_lock_hit;
  logic                w_win_valid;
  logic [TAGW-1:0]     w_win_id;
  logic                w_win_op;
  logic                w_issue;
  logic                w_start_drain;
  logic                w_lock_drop;
  logic                w_tail_v;
  logic [TAGW-1:0]     w_tail_id;

  // Only bit 0 of each op field is meaningful.
  logic [NUM_REQ-1:0]  w_unused_op_hi;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op_hi
    assign w_unused_op_hi[gi] = req_op[2*gi+1];
  end

  // Round-robin search starting just after the last issuer, with wrap.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_rr_found && req_valid[TAGW'(v_idx)]) begin
        w_rr_found = 1'b1;
        w_rr_id    = TAGW'(v_idx);
      end
    end
  end

  // A requester that forced an op switch goes first once the switch is done,
  // but only while it is still asking; otherwise round-robin takes over.
  assign w_lock_hit  = r_lock_valid && req_valid[r_lock_id];
  assign w_win_valid = w_lock_hit || w_rr_found;
  assign w_win_id    = w_lock_hit ? r_lock_id : w_rr_id;
  assign w_win_op    = req_op[{w_win_id, 1'b0}];
  assign w_lock_drop = (r_state == S_RUN) && r_lock_valid && !req_valid[r_lock_id];

  assign w_tail_v  = r_tag_v[LATENCY-1];
  assign w_tail_id = r_tag_id[LATENCY-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  // Next state and issue decision. Issue is held off while rst is high so the
  // combinational handshake outputs show their reset values immediately.
  always_comb begin
    w_state_next  = r_state;
    w_issue       = 1'b0;
    w_start_drain = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!rst && w_win_valid) begin
          if (w_win_op == r_cur_op) begin
            w_issue = 1'b1;
          end else begin
            w_start_drain = 1'b1;
            w_state_next  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_inflight == '0) w_state_next = S_SWITCH;
      end
      S_SWITCH: w_state_next = S_RUN;
      default:  w_state_next = S_RUN;
    endcase
  end

  assign req_ready       = w_issue ? (NUM_REQ'(1) << w_win_id) : '0;
  assign pe_t_valid_inp1 = w_issue;
  assign pe_inp1         = w_issue ? req_data[int'(w_win_id)*DWIDTH +: DWIDTH] : '0;
  assign pe_op           = {1'b0, r_cur_op};

  // Arbitration bookkeeping, op switch and lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_op     <= 1'b0;
      r_pend_op    <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_id    <= '0;
      r_rr_ptr     <= TAGW'(NUM_REQ - 1);
    end else begin
      if (w_issue) r_rr_ptr <= w_win_id;
      if (w_start_drain) begin
        r_lock_valid <= 1'b1;
        r_lock_id    <= w_win_id;
        r_pend_op    <= w_win_op;
      end else if ((w_issue && w_lock_hit) || w_lock_drop) begin
        r_lock_valid <= 1'b0;
      end
      if (r_state == S_SWITCH) r_cur_op <= r_pend_op;
    end
  end

  // Tag pipe: stage 0 records this cycle's issue, tail lines up with the PE output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_issue ? w_win_id : '0;
      for (int s = 1; s < LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // In-flight count follows the tag pipe, not the PE valid, so a missing PE
  // valid cannot leave the count stuck.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_tail_v})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Response steering and orphan detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (pe_t_valid_out1 && w_tail_v) begin
        r_rsp_valid <= NUM_REQ'(1) << w_tail_id;
        r_rsp_data  <= pe_out1;
      end else begin
        r_rsp_valid <= '0;
      end
      if (pe_t_valid_out1 != w_tail_v) r_err_orphan <= 1'b1;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign err_orphan = r_err_orphan;
  assign busy       = (r_inflight != '0) || (r_state != S_RUN);

endmodule

// File: tb/tb_pe_typeb_scheduler.sv
module tb_pe_typeb_scheduler;

  localparam int NR = 4;
  localparam int L  = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR*2-1:0]   req_op    = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     pe_inp1;
  logic              pe_t_valid_inp1;
  logic [1:0]        pe_op;
  logic [DW-1:0]     pe_out1;
  logic              pe_t_valid_out1;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic              err_orphan;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_typeb_scheduler #(.NUM_REQ(NR), .LATENCY(L), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_op(req_op),
    .req_ready(req_ready),
    .pe_inp1(pe_inp1), .pe_t_valid_inp1(pe_t_valid_inp1), .pe_op(pe_op),
    .pe_out1(pe_out1), .pe_t_valid_out1(pe_t_valid_out1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err_orphan(err_orphan)
  );

  // PE model: fixed-latency pipe, output muxed on the live op. Not reset by rst,
  // like a real PE that keeps shifting stale work out.
  logic          pe_early = 1'b0;
  logic          inj      = 1'b0;
  logic          pv [L];
  logic [DW-1:0] pd [L];
  logic [DW-1:0] pe_sel;

  always_ff @(posedge clk) begin
    pv[0] <= pe_t_valid_inp1;
    pd[0] <= pe_inp1;
    for (int s = 1; s < L; s++) begin
      pv[s] <= pv[s-1];
      pd[s] <= pd[s-1];
    end
  end

  assign pe_sel          = pe_early ? pd[L-2] : pd[L-1];
  assign pe_t_valid_out1 = (pe_early ? pv[L-2] : pv[L-1]) | inj;
  assign pe_out1         = pe_op[0] ? $realtobits(real'($signed(pe_sel))) : pe_sel;

  // One line per transaction
  always @(posedge clk) begin
    if (!rst && (|(req_valid & req_ready)))
      $display("issue   ready=%b data=%h pe_op=%b", req_ready, pe_inp1, pe_op);
    if (!rst && (|rsp_valid))
      $display("respond valid=%b data=%h", rsp_valid, rsp_data);
  end

  task automatic set_req(input int i, input logic v, input logic op, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_op[2*i +: 2]     = {1'b0, op};
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    inj       = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 64'(i + 1));
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (pe_t_valid_inp1 !== 1'b0) begin n_err++; $display("FAIL reset_pe_valid: got %b expected 0", pe_t_valid_inp1); end
    n_cmp++; if (pe_inp1 !== 64'd0) begin n_err++; $display("FAIL reset_pe_inp1: got %h expected 0", pe_inp1); end
    n_cmp++; if (pe_op !== 2'b00) begin n_err++; $display("FAIL reset_pe_op: got %b expected 00", pe_op); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_orphan); end
    do_reset();
  endtask

  // Requester 0 asks for convert while cur_op=0: drain (empty), switch, then issue.
  task automatic test_single();
    int n;
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 64'd5);
    #1;
    n = 0;
    while (req_ready !== 4'b0001 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL single_issue_delay: got %0d cycles expected 3", n); end
    n_cmp++; if (pe_t_valid_inp1 !== 1'b1 || pe_inp1 !== 64'd5) begin n_err++; $display("FAIL single_issue: got valid=%b data=%h expected 1/5", pe_t_valid_inp1, pe_inp1); end
    n_cmp++; if (pe_op !== 2'b01) begin n_err++; $display("FAIL single_pe_op: got %b expected 01", pe_op); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      n_cmp++; if (rsp_valid !== ((k == 5) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL single_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, (k == 5) ? 4'b0001 : 4'b0000); end
      if (k == 5) begin
        n_cmp++; if (rsp_data !== 64'h4014000000000000) begin n_err++; $display("FAIL single_rsp_data: got %h expected 4014000000000000", rsp_data); end
      end
    end
    n_cmp++; if (busy !== 1'b0 || err_orphan !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b err=%b expected 0/0", busy, err_orphan); end
  endtask

  // All four requesters valid, op=0: grants rotate and responses return in order.
  task automatic test_round_robin();
    logic [NR-1:0] e_v;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 64'(100 + i));
      if (c == 5) req_valid = '0;
      #1;
      if (c < 5) begin
        e_v = 4'b0001 << (c % 4);
        n_cmp++; if (req_ready !== e_v) begin n_err++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, e_v); end
        n_cmp++; if (pe_inp1 !== 64'(100 + c % 4)) begin n_err++; $display("FAIL rr_pe_inp1 c=%0d: got %h expected %h", c, pe_inp1, 64'(100 + c % 4)); end
      end else begin
        e_v = 4'b0001 << ((c - 5) % 4);
        n_cmp++; if (rsp_valid !== e_v) begin n_err++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); end
        n_cmp++; if (rsp_data !== 64'(100 + (c - 5) % 4)) begin n_err++; $display("FAIL rr_rsp_data c=%0d: got %h expected %h", c, rsp_data, 64'(100 + (c - 5) % 4)); end
      end
      if (c == 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rr_busy_on: got %b expected 1", busy); end
      end
      if (c == 9) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_off: got %b expected 0", busy); end
      end
    end
  endtask

  // Requester 1 streams op=0, requester 2 then wants op=1: drain, switch, 2 first.
  task automatic test_op_switch();
    logic [NR-1:0] e_rdy, e_rsp;
    logic [1:0]    e_op;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0)  set_req(1, 1'b1, 1'b0, 64'h11);
      if (c == 3)  set_req(2, 1'b1, 1'b1, 64'd7);
      if (c == 10) req_valid = '0;
      #1;
      e_rdy = (c < 3) ? 4'b0010 : (c == 9) ? 4'b0100 : 4'b0000;
      e_op  = (c < 9) ? 2'b00 : 2'b01;
      e_rsp = (c >= 5 && c <= 7) ? 4'b0010 : (c == 14) ? 4'b0100 : 4'b0000;
      n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL sw_ready c=%0d: got %b expected %b", c, req_ready, e_rdy); end
      n_cmp++; if (pe_op !== e_op) begin n_err++; $display("FAIL sw_pe_op c=%0d: got %b expected %b", c, pe_op, e_op); end
      n_cmp++; if (rsp_valid !== e_rsp) begin n_err++; $display("FAIL sw_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_rsp); end
      if (c >= 5 && c <= 7) begin
        n_cmp++; if (rsp_data !== 64'h11) begin n_err++; $display("FAIL sw_rsp_data c=%0d: got %h expected 11", c, rsp_data); end
      end
      if (c == 14) begin
        n_cmp++; if (rsp_data !== 64'h401C000000000000) begin n_err++; $display("FAIL sw_rsp_conv: got %h expected 401c000000000000", rsp_data); end
      end
    end
  endtask

  // Locked requester 2 drops valid during DRAIN; requester 3 wins after SWITCH.
  task automatic test_lock_drop();
    logic [NR-1:0] e_rdy, e_rsp;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) set_req(0, 1'b1, 1'b0, 64'h20);
      if (c == 2) begin req_valid = '0; set_req(2, 1'b1, 1'b1, 64'h22); end
      if (c == 4) begin req_valid[2] = 1'b0; set_req(3, 1'b1, 1'b1, 64'd3); set_req(0, 1'b1, 1'b0, 64'h20); end
      if (c == 9) req_valid = '0;
      #1;
      e_rdy = (c < 2) ? 4'b0001 : (c == 8) ? 4'b1000 : 4'b0000;
      e_rsp = (c == 5 || c == 6) ? 4'b0001 : (c == 13) ? 4'b1000 : 4'b0000;
      n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL lock_ready c=%0d: got %b expected %b", c, req_ready, e_rdy); end
      n_cmp++; if (rsp_valid !== e_rsp) begin n_err++; $display("FAIL lock_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_rsp); end
      if (c == 13) begin
        n_cmp++; if (rsp_data !== 64'h4008000000000000) begin n_err++; $display("FAIL lock_rsp_data: got %h expected 4008000000000000", rsp_data); end
      end
    end
  endtask

  // Reset two cycles after three issues; stale and injected PE valids are orphans.
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) set_req(3, 1'b1, 1'b0, 64'h33);
      if (c == 3) req_valid = '0;
      if (c == 4) begin rst = 1'b1; req_valid[3] = 1'b1; end
      if (c == 5) begin rst = 1'b0; req_valid = '0; end
      if (c == 6) inj = 1'b1;
      if (c == 7) inj = 1'b0;
      #1;
      if (c == 3) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
      end
      if (c == 4) begin
        n_cmp++; if (req_ready !== 4'b0000 || pe_t_valid_inp1 !== 1'b0 || pe_inp1 !== 64'd0) begin n_err++; $display("FAIL rmid_issue_side: got ready=%b valid=%b data=%h expected 0", req_ready, pe_t_valid_inp1, pe_inp1); end
        n_cmp++; if (busy !== 1'b0 || pe_op !== 2'b00) begin n_err++; $display("FAIL rmid_state: got busy=%b pe_op=%b expected 0/00", busy, pe_op); end
      end
      if (c == 5) begin
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rmid_err_clear: got %b expected 0", err_orphan); end
      end
      if (c >= 4) begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rmid_rsp c=%0d: got %b expected 0000", c, rsp_valid); end
      end
      if (c == 9) begin
        n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL rmid_err_set: got %b expected 1", err_orphan); end
      end
    end
  endtask

  // PE valid one cycle early: both mismatches flag orphan, nothing is steered.
  task automatic test_early_valid();
    do_reset();
    pe_early = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) set_req(1, 1'b1, 1'b0, 64'h42);
      if (c == 1) req_valid = '0;
      #1;
      if (c == 0) begin
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL early_ready: got %b expected 0010", req_ready); end
      end else begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL early_rsp c=%0d: got %b expected 0000", c, rsp_valid); end
      end
      if (c == 3) begin
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL early_err_pre: got %b expected 0", err_orphan); end
      end
      if (c == 8) begin
        n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL early_err_set: got %b expected 1", err_orphan); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL early_busy: got %b expected 0", busy); end
      end
    end
    pe_early = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_op_switch();
    test_lock_drop();
    test_reset_mid();
    test_early_valid();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_typeb_scheduler.md
Name: pe_typeb_scheduler

Overview:
- Round-robin scheduler that shares one PE_typeB-style int64-to-double converter/bypass PE among NUM_REQ requesters.
- Accepts per-requester valid/ready requests carrying a 64-bit operand and an op code.
- Drives the shared PE's input, valid and op lines.
- Steers each PE result back to the requester that issued it, using a tag pipeline matched to the PE latency.
- The PE muxes its output on the live op value, so the scheduler holds op constant while results are in flight. It drains the pipe before switching op.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 4, PE issue-to-output latency in cycles; must equal the PE's latency parameter
- DWIDTH, 64, operand/result width (dwidth_double)
- TAGW, $clog2(NUM_REQ), tag width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*DWIDTH  operands; requester i occupies bits [i*DWIDTH +: DWIDTH]
- req_op  in  NUM_REQ*2  per-requester op; only bit 0 is used (1 = convert, 0 = bypass)
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
- pe_inp1  out  DWIDTH  operand to the PE
- pe_t_valid_inp1  out  1  PE input valid
- pe_op  out  2  PE op; bit 1 is tied to 0
- pe_out1  in  DWIDTH  PE result
- pe_t_valid_out1  in  1  PE result valid
- rsp_valid  out  NUM_REQ  one-hot response valid (no backpressure)
- rsp_data  out  DWIDTH  response data, shared by all requesters
- busy  out  1  in-flight count is nonzero or FSM is not in RUN
- err_orphan  out  1  sticky flag: PE valid arrived with no matching tag

Behaviour:
- Reset values: req_ready=0, pe_t_valid_inp1=0, pe_inp1=0, pe_op=0, rsp_valid=0, rsp_data=0, busy=0, err_orphan=0.
- Reset also clears: FSM=RUN, cur_op=0, rr_ptr=NUM_REQ-1, inflight=0, tag pipe cleared.
- Arbitration: the winner is the first requester with req_valid=1, searching from rr_ptr+1 with wrap-around. rr_ptr updates to the winner only when that winner issues.
- State RUN:
  - If a winner W exists and req_op[W][0]==cur_op: req_ready[W]=1 (combinational), and in the same cycle pe_inp1=req_data[W] and pe_t_valid_inp1=1 (combinational, zero-cycle issue). Push {1,W} into the tag pipe.
  - If W's op differs: no issue. Latch lock_id=W and pend_op=req_op[W][0], then go to DRAIN.
  - No winner: push {0,x} into the tag pipe.
- State DRAIN:
  - No issue; all req_ready=0.
  - When inflight==0, go to SWITCH.
- State SWITCH (one cycle):
  - cur_op<=pend_op.
  - Next cycle in RUN, lock_id has priority regardless of rr_ptr. The lock clears when it issues. If lock_id has dropped req_valid, the lock clears and normal round-robin resumes.
- At most one issue per cycle. Issue throughput is 1/cycle for same-op traffic.
- Tag pipe: LATENCY stages of {valid, tag}, shifting every cycle.
- Response (registered, one cycle after pe_t_valid_out1):
  - When pe_t_valid_out1=1 and the tail stage is valid: rsp_valid<=onehot(tail tag) and rsp_data<=pe_out1.
  - Otherwise rsp_valid<=0; rsp_data holds its value.
  - Issue-to-rsp_valid latency is exactly LATENCY+1.
- Orphan/miss cases:
  - pe_t_valid_out1=1 with the tail stage invalid: result dropped, err_orphan<=1. err_orphan clears only on rst.
  - Tail stage valid with pe_t_valid_out1=0: err_orphan<=1, and inflight still decrements.
- inflight (width $clog2(LATENCY+2)) increments on issue and decrements on tail-valid. A simultaneous increment and decrement leaves it unchanged. It never exceeds LATENCY.
- pe_op={1'b0,cur_op}; it changes only in SWITCH, so it never changes while inflight>0.
- Reset mid-operation discards all in-flight tags. Stale PE valids arriving afterward set err_orphan and are dropped.

Test Plan:
- Single requester 0, op=1, data=64'd5 -> req_ready[0] in the issue cycle. rsp_valid=4'b0001 exactly 5 cycles later, rsp_data=pe_out1 (0x4014000000000000 from a PE model). inflight returns to 0.
- All 4 requesters continuously valid, op=0 -> grants rotate 0,1,2,3,0 with one issue/cycle. Responses return in the same order, with rsp_data equal to each requester's own operand.
- Requester 1 op=0 streaming, then requester 2 asserts op=1 -> issues stop, pe_op unchanged until the last of ≤4 responses returns. SWITCH sets pe_op=2'b01, and requester 2 issues first after the switch.
- Locked requester 2 drops valid during DRAIN -> after SWITCH the lock clears and the next valid requester in round-robin order issues. No deadlock.
- rst asserted 2 cycles after three issues -> all outputs go to reset values immediately. Injected PE valid 2 cycles later sets err_orphan=1, and rsp_valid stays 0.
- PE model asserts pe_t_valid_out1 one cycle early -> err_orphan=1. No response is steered to any requester.
